// File: rtl/memory_store_unit.sv
// Store side of the banked data memory: alignment check, byte-lane steering, and a small
// FIFO that drains one entry per cycle into four byte-wide banks. Flags loads that hit a buffered store.
`ifndef MEMORY_SIZE_BYTES
`define MEMORY_SIZE_BYTES 1024
`endif

package memory_store_pkg;
   typedef enum logic [1:0] {
      BYTE     = 2'd0,
      HALFWORD = 2'd1,
      WORD     = 2'd2
   } load_type;
endpackage

module memory_store_unit
   import memory_store_pkg::*;
#(
   parameter  int MEMORY_SIZE = `MEMORY_SIZE_BYTES,
   parameter  int DEPTH       = 4,
   localparam int IDX_W       = $clog2(MEMORY_SIZE / 4)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             st_valid,
   output logic             st_ready,
   input  logic [31:0]      st_addr,
   input  load_type         st_type,
   input  logic [31:0]      st_data,
   output logic             misaligned,
   output logic [31:0]      misaligned_addr,
   input  logic             mem_busy,
   output logic [3:0]       bank_we,
   output logic [IDX_W-1:0] bank_index,
   output logic [31:0]      bank_wdata,
   input  logic [31:0]      query_addr,
   output logic             query_hit,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [IDX_W-1:0] index;
      logic [3:0]       we;
      logic [31:0]      data;
   } entry_t;

   entry_t             buf_q [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               misaligned_q, misaligned_d;
   logic [31:0]        mis_addr_q, mis_addr_d;
   logic [IDX_W-1:0]   bank_index_q, bank_index_d;
   logic [31:0]        bank_wdata_q, bank_wdata_d;

   logic               full, accept, aligned, push, pop;
   logic [3:0]         lane_we;
   logic [31:0]        lane_data;
   entry_t             new_entry, head_entry;
   logic [IDX_W-1:0]   q_idx;
   logic               unused_bits;

   assign unused_bits = ^{st_addr[31:IDX_W+2], query_addr[31:IDX_W+2], query_addr[1:0]};

   assign full     = (count_q == (PTR_W+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign st_ready = !full;
   assign accept   = st_valid && st_ready;
   assign push     = accept && aligned;
   assign pop      = !empty && !mem_busy;

   always_comb begin
      aligned   = 1'b0;
      lane_we   = 4'b0000;
      lane_data = 32'h0;
      case (st_type)
         BYTE: begin
            aligned   = 1'b1;
            lane_we   = 4'b0001 << st_addr[1:0];
            lane_data = {4{st_data[7:0]}};
         end
         HALFWORD: begin
            aligned   = !st_addr[0];
            lane_we   = 4'b0011 << st_addr[1:0];
            lane_data = {2{st_data[15:0]}};
         end
         WORD: begin
            aligned   = (st_addr[1:0] == 2'b00);
            lane_we   = 4'b1111;
            lane_data = st_data;
         end
         default: aligned = 1'b0;
      endcase
   end

   assign new_entry  = '{index: st_addr[IDX_W+1:2], we: lane_we, data: lane_data};
   assign head_entry = buf_q[head_q];

   assign bank_we    = pop ? head_entry.we    : 4'b0000;
   assign bank_index = pop ? head_entry.index : bank_index_q;
   assign bank_wdata = pop ? head_entry.data  : bank_wdata_q;

   assign misaligned      = misaligned_q;
   assign misaligned_addr = mis_addr_q;

   // An entry is live when its distance from head is below count; head counts even while draining.
   assign q_idx = query_addr[IDX_W+1:2];
   always_comb begin
      query_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q) && (buf_q[i].index == q_idx))
            query_hit = 1'b1;
      end
   end

   always_comb begin
      head_d       = head_q + PTR_W'(pop);
      tail_d       = tail_q + PTR_W'(push);
      count_d      = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      misaligned_d = accept && !aligned;
      mis_addr_d   = (accept && !aligned) ? st_addr : mis_addr_q;
      bank_index_d = pop ? head_entry.index : bank_index_q;
      bank_wdata_d = pop ? head_entry.data  : bank_wdata_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         misaligned_q <= 1'b0;
         mis_addr_q   <= 32'h0;
         bank_index_q <= '0;
         bank_wdata_q <= 32'h0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         misaligned_q <= misaligned_d;
         mis_addr_q   <= mis_addr_d;
         bank_index_q <= bank_index_d;
         bank_wdata_q <= bank_wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) buf_q[tail_q] <= new_entry;
   end

endmodule
